// File: rtl/fetch_pkg.sv
// Shared constants and the fill FSM state type for the instruction-cache fill path.
// Cache and fetch stages import the same widths so block and address sizes agree.
package fetch_pkg;

  localparam int BEAT_WIDTH   = 64;
  localparam int BEATS        = 4;
  localparam int BLOCK_WIDTH  = 256;
  localparam int CACHE_LINES  = 256;
  localparam int WADDR_WIDTH  = 16;
  localparam int FADDR_WIDTH  = 11;
  localparam int WRITE_HOLD   = 2;
  localparam int STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PENDING,
    ST_WRITE
  } fill_state_e;

endpackage

// File: rtl/fill_block_assembler.sv
// Collects memory beats into one cache block, beat 0 in the least significant slot.
// o_blockFull flags the transfer that completes the block.
module fill_block_assembler
  import fetch_pkg::*;
#(
  parameter int P_BEAT_WIDTH = BEAT_WIDTH,
  parameter int P_BEATS      = BEATS
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            i_start,
  input  logic                            i_beatValid,
  input  logic [P_BEAT_WIDTH-1:0]         i_beatData,
  output logic [P_BEAT_WIDTH*P_BEATS-1:0] o_block,
  output logic                            o_blockFull
);

  localparam int CNT_W = (P_BEATS > 1) ? $clog2(P_BEATS) : 1;

  logic [CNT_W-1:0]                r_beatCnt;
  logic [P_BEAT_WIDTH*P_BEATS-1:0] r_buffer;
  logic                            w_lastBeat;

  assign w_lastBeat  = (r_beatCnt == CNT_W'(P_BEATS - 1));
  assign o_blockFull = i_beatValid && w_lastBeat;
  assign o_block     = r_buffer;

  // The counter returns to zero on the completing beat, so it never wraps on its own.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_beatCnt <= '0;
      r_buffer  <= '0;
    end else if (i_start) begin
      r_beatCnt <= '0;
    end else if (i_beatValid) begin
      r_buffer[r_beatCnt*P_BEAT_WIDTH +: P_BEAT_WIDTH] <= i_beatData;
      if (w_lastBeat) begin
        r_beatCnt <= '0;
      end else begin
        r_beatCnt <= r_beatCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/icache_fill_ctrl.sv
// Arbitrates the single-port instruction cache between fetch and block refill.
// A refill is assembled in the background and then holds the write port for a fixed window.
module icache_fill_ctrl
  import fetch_pkg::*;
#(
  parameter int P_BEAT_WIDTH   = BEAT_WIDTH,
  parameter int P_BEATS        = BEATS,
  parameter int P_BLOCK_WIDTH  = BLOCK_WIDTH,
  parameter int P_CACHE_LINES  = CACHE_LINES,
  parameter int P_WADDR_WIDTH  = WADDR_WIDTH,
  parameter int P_FADDR_WIDTH  = FADDR_WIDTH,
  parameter int P_WRITE_HOLD   = WRITE_HOLD,
  parameter int P_STARVE_LIMIT = STARVE_LIMIT
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     fetchReq_i,
  input  logic [P_FADDR_WIDTH-1:0] fetchAddr_i,
  output logic                     fetchGrant_o,
  output logic [P_FADDR_WIDTH-1:0] blockAddr_o,
  input  logic                     fillReq_i,
  input  logic [P_WADDR_WIDTH-1:0] fillAddr_i,
  output logic                     fillBusy_o,
  input  logic                     memValid_i,
  input  logic [P_BEAT_WIDTH-1:0]  memData_i,
  output logic                     memReady_o,
  output logic                     writeEnable_o,
  output logic [P_WADDR_WIDTH-1:0] writeAddress_o,
  output logic [P_BLOCK_WIDTH-1:0] writeBlock_o,
  output logic                     fillDone_o,
  output logic                     fillErr_o
);

  localparam int STARVE_W = $clog2(P_STARVE_LIMIT + 1);
  localparam int HOLD_W   = $clog2(P_WRITE_HOLD + 1);
  localparam logic [P_WADDR_WIDTH:0] LINES_LIMIT = (P_WADDR_WIDTH + 1)'(P_CACHE_LINES);

  fill_state_e                r_state;
  fill_state_e                w_nextState;
  logic [P_WADDR_WIDTH-1:0]   r_fillAddr;
  logic [STARVE_W-1:0]        r_starveCnt;
  logic [HOLD_W-1:0]          r_holdCnt;
  logic                       r_fetchGrant;
  logic [P_FADDR_WIDTH-1:0]   r_blockAddr;
  logic [P_WADDR_WIDTH-1:0]   r_writeAddr;
  logic [P_BLOCK_WIDTH-1:0]   r_writeBlock;
  logic                       r_fillDone;
  logic                       r_fillErr;

  logic                       w_beatXfer;
  logic                       w_blockFull;
  logic [P_BLOCK_WIDTH-1:0]   w_block;
  logic                       w_fillAccept;
  logic                       w_fillReject;
  logic                       w_enterWrite;
  logic                       w_holdLast;
  logic                       w_starveOut;
  logic                       w_fetchWin;

  assign memReady_o     = (r_state == ST_COLLECT);
  assign fillBusy_o     = (r_state != ST_IDLE);
  assign writeEnable_o  = (r_state == ST_WRITE);
  assign fetchGrant_o   = r_fetchGrant;
  assign blockAddr_o    = r_blockAddr;
  assign writeAddress_o = r_writeAddr;
  assign writeBlock_o   = r_writeBlock;
  assign fillDone_o     = r_fillDone;
  assign fillErr_o      = r_fillErr;

  assign w_beatXfer  = memValid_i && memReady_o;
  assign w_holdLast  = (r_holdCnt == HOLD_W'(P_WRITE_HOLD - 1));
  assign w_starveOut = (r_starveCnt >= STARVE_W'(P_STARVE_LIMIT - 1));

  fill_block_assembler #(
    .P_BEAT_WIDTH (P_BEAT_WIDTH),
    .P_BEATS      (P_BEATS)
  ) u_assembler (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .i_start     (w_fillAccept),
    .i_beatValid (w_beatXfer),
    .i_beatData  (memData_i),
    .o_block     (w_block),
    .o_blockFull (w_blockFull)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Fetch yields only while a starved block is forced through or the write port is held.
  always_comb begin
    w_nextState  = r_state;
    w_fillAccept = 1'b0;
    w_fillReject = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fillReq_i) begin
          if ({1'b0, fillAddr_i} >= LINES_LIMIT) begin
            w_fillReject = 1'b1;
          end else begin
            w_fillAccept = 1'b1;
            w_nextState  = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (w_blockFull) begin
          w_nextState = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (!fetchReq_i || w_starveOut) begin
          w_nextState = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_holdLast) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign w_enterWrite = (r_state == ST_PENDING) && (w_nextState == ST_WRITE);
  assign w_fetchWin   = fetchReq_i && (r_state != ST_WRITE) && !w_enterWrite;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_starveCnt <= '0;
      r_holdCnt   <= '0;
    end else begin
      if (r_state != ST_PENDING) begin
        r_starveCnt <= '0;
      end else if (fetchReq_i && (r_starveCnt < STARVE_W'(P_STARVE_LIMIT))) begin
        r_starveCnt <= r_starveCnt + STARVE_W'(1);
      end
      if ((r_state == ST_WRITE) && !w_holdLast) begin
        r_holdCnt <= r_holdCnt + HOLD_W'(1);
      end else begin
        r_holdCnt <= '0;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_fetchGrant <= 1'b0;
      r_blockAddr  <= '0;
    end else begin
      r_fetchGrant <= w_fetchWin;
      if (w_fetchWin) begin
        r_blockAddr <= fetchAddr_i;
      end
    end
  end

  // Write controls are captured once on entry and then held until the next write.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_fillAddr   <= '0;
      r_writeAddr  <= '0;
      r_writeBlock <= '0;
      r_fillDone   <= 1'b0;
      r_fillErr    <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && fillReq_i) begin
        r_fillAddr <= fillAddr_i;
      end
      if (w_enterWrite) begin
        r_writeAddr  <= r_fillAddr;
        r_writeBlock <= w_block;
      end
      r_fillDone <= w_fillReject || ((r_state == ST_WRITE) && w_holdLast);
      r_fillErr  <= w_fillReject;
    end
  end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Sequences the single-port L1 instruction cache between two requesters: the fetch address stream and the memory refill path.
- Assembles a 256-bit block from 64-bit memory beats in the background.
- Then claims the cache write port for a fixed hold window, stalling fetch only during that window.
- Sits between the fetch address generator / memory interface and the cache's blockAddr/write ports.

Parameters:
- BEAT_WIDTH, 64, memory beat width in bits
- BEATS, 4, beats per block (BEAT_WIDTH*BEATS = block width)
- BLOCK_WIDTH, 256, cache block width in bits
- CACHE_LINES, 256, valid cache lines; fill addresses >= this are rejected
- WADDR_WIDTH, 16, cache write address width
- FADDR_WIDTH, 11, fetch block address width
- WRITE_HOLD, 2, cycles writeEnable_o stays high (cache registers write controls one cycle before use)
- STARVE_LIMIT, 8, max cycles an assembled block waits behind fetch before forcing the write

Ports:
- clock_i  in  1  clock; all state on rising edge
- reset_i  in  1  asynchronous, active-high reset
- fetchReq_i  in  1  fetch wants a block this cycle
- fetchAddr_i  in  FADDR_WIDTH  requested block address
- fetchGrant_o  out  1  registered: blockAddr_o carries a granted fetch address
- blockAddr_o  out  FADDR_WIDTH  registered block address to cache
- fillReq_i  in  1  start refill of one block
- fillAddr_i  in  WADDR_WIDTH  target line of refill
- fillBusy_o  out  1  refill in progress; fillReq_i ignored while high
- memValid_i  in  1  beat valid
- memData_i  in  BEAT_WIDTH  beat data
- memReady_o  out  1  controller accepts a beat (beat transfers when memValid_i & memReady_o)
- writeEnable_o  out  1  cache write strobe
- writeAddress_o  out  WADDR_WIDTH  cache write line
- writeBlock_o  out  BLOCK_WIDTH  cache write data
- fillDone_o  out  1  one-cycle pulse: fill finished (written or rejected)
- fillErr_o  out  1  one-cycle pulse with fillDone_o when fillAddr out of range

Behaviour:
- Reset (async, any state):
  - all outputs 0, FSM to IDLE, beat/starve/hold counters 0, assembly buffer 0.
  - A partial or pending fill is discarded with no write and no fillDone_o.
- FSM states: IDLE, COLLECT, PENDING, WRITE.
- IDLE:
  - memReady_o=0, fillBusy_o=0.
  - On fillReq_i, latch fillAddr_i.
  - If fillAddr_i >= CACHE_LINES: pulse fillDone_o and fillErr_o next cycle, stay IDLE.
  - Otherwise go to COLLECT with beat counter = 0.
- COLLECT:
  - memReady_o=1, fillBusy_o=1.
  - Beat k is stored in bits [k*BEAT_WIDTH +: BEAT_WIDTH]; beat 0 is least significant.
  - After beat BEATS-1 transfers, go to PENDING; memReady_o drops the same edge.
  - No timeout; memValid_i gaps are allowed.
- PENDING:
  - If fetchReq_i=0, go to WRITE next edge.
  - Else increment starve counter; when it reaches STARVE_LIMIT, go to WRITE regardless.
- WRITE:
  - writeEnable_o=1 for exactly WRITE_HOLD cycles.
  - writeAddress_o/writeBlock_o stable for the whole window and held after it; they change only on the next write.
  - Leave WRITE on the last hold cycle: writeEnable_o to 0, fillDone_o pulses for 1 cycle, fillBusy_o to 0, state IDLE.
  - A fillReq_i on the fillDone_o cycle is accepted (IDLE logic applies).
- Fetch path (registered, 1-cycle latency):
  - If fetchReq_i and state != WRITE and not entering WRITE this edge: blockAddr_o <= fetchAddr_i, fetchGrant_o <= 1.
  - Else fetchGrant_o <= 0 and blockAddr_o holds.
  - Fetch is never granted while writeEnable_o=1.
  - Fetch is unaffected during COLLECT.
- memValid_i while memReady_o=0: ignored, no data captured.
- Widths: beat counter is clog2(BEATS) bits and wraps only via the state change. Starve counter saturates at STARVE_LIMIT.

Decomposition:
- Shared package fetch_pkg:
  - FSM state enum
  - BLOCK_WIDTH, BEAT_WIDTH, BEATS, CACHE_LINES, address-width constants (shared with the cache and fetch stages)
- One natural sub-module: fill_block_assembler (beat counter, shift/indexed capture into a 256-bit buffer, block_full flag).
- Controller keeps FSM, arbitration and starve counter.

Test Plan:
- Reset mid-COLLECT after 2 beats, then new fill to line 5 with beats 0x11..,0x22..,0x33..,0x44.. -> line 5 written with beat 0x11.. in bits [63:0], single fillDone_o, no write from aborted fill.
- Fill addr 0x0003, fetchReq_i low -> writeEnable_o high exactly 2 cycles, writeAddress_o=3, fillDone_o 1 cycle after, fetchGrant_o 0 during write.
- Continuous fetchReq_i (addr 0x010) during fill -> grants continue through COLLECT; PENDING waits 8 cycles, then write forced; grants resume the cycle after writeEnable_o falls.
- Fill addr 0x0100 (=CACHE_LINES) -> fillDone_o=fillErr_o=1 for 1 cycle, no writeEnable_o, no memReady_o.
- fillReq_i during COLLECT with different addr -> ignored, original address written; memValid_i pulses while memReady_o=0 -> no capture.
- Back-to-back fills with second fillReq_i on fillDone_o cycle -> second accepted, two distinct lines written correctly.
